// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM state encoding for the SPI slave memory
package spi_pkg;

  localparam int DATA_W     = 8;
  localparam int CMD_BITS   = 9;
  localparam int FRAME_BITS = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_CMD  = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_STORE   = 3'd3,
    ST_FETCH   = 3'd4,
    ST_TX_DATA = 3'd5
  } state_t;

endpackage

// File: rtl/spi_mem_array.sv
// rtl/spi_mem_array.sv - DEPTH x 8 storage, synchronous write, combinational read
// SPI_MEM_INIT_EN defined: every location clears to 0x00 while rst is low.
module spi_mem_array
  import spi_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef SPI_MEM_INIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  // Without init the array carries no reset; the port stays for a uniform interface.
  logic unused_rst;
  assign unused_rst = rst;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_slave_mem.sv
// rtl/spi_slave_mem.sv - SPI-style slave: 17-bit write / 9-bit read frames into a byte memory
// Memory reset on rst is enabled by defining SPI_MEM_INIT_EN.
module spi_slave_mem
  import spi_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done
);

  localparam int AW = $clog2(DEPTH);

  state_t            state;
  logic [4:0]        cnt;
  logic              wr;
  logic [7:0]        addr;
  logic [7:0]        wdata;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] mem_rdata;
  logic              in_range;
  logic              mem_we;

  // Full 8-bit address is compared so high addresses never alias onto low locations.
  assign in_range = ({1'b0, addr} < 9'(DEPTH));
  assign mem_we   = (state == ST_STORE) && in_range;

  spi_mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(addr[AW-1:0]),
    .wdata(wdata),
    .raddr(addr[AW-1:0]),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      wr      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      shreg   <= '0;
      miso    <= 1'b0;
      ready   <= 1'b0;
      op_done <= 1'b0;
    end else begin
      ready   <= 1'b0;
      op_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          miso <= 1'b0;
          if (!cs) begin
            wr    <= mosi;
            cnt   <= 5'd1;
            state <= ST_RX_CMD;
          end
        end
        ST_RX_CMD: begin
          if (cs) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            addr <= {mosi, addr[7:1]};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'(CMD_BITS - 1)) begin
              state <= wr ? ST_RX_DATA : ST_FETCH;
            end
          end
        end
        ST_RX_DATA: begin
          if (cs) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            wdata <= {mosi, wdata[7:1]};
            cnt   <= cnt + 5'd1;
            if (cnt == 5'(FRAME_BITS - 1)) begin
              op_done <= 1'b1;
              state   <= ST_STORE;
            end
          end
        end
        ST_STORE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        ST_FETCH: begin
          shreg <= in_range ? mem_rdata : '0;
          ready <= 1'b1;
          cnt   <= '0;
          state <= ST_TX_DATA;
        end
        ST_TX_DATA: begin
          // cnt counts bits already driven; the ready cycle itself drives nothing.
          if (cnt == 5'(DATA_W)) begin
            miso  <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            miso  <= shreg[0];
            shreg <= {1'b0, shreg[DATA_W-1:1]};
            cnt   <= cnt + 5'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
